seg_shift_driver: RTL and testbench

- Downstream serialiser for the 7-segment display path.
- Sweeps the 3-bit scan index into the segment-map stage and captures the 8-bit pattern returned for each index, building one 64-bit frame.
- Shifts the frame out MSB-first to an external 74HC595-style shift-register chain on sclk/sdat, then pulses the latch line.
- Sits between the segment-map stage and the board pins; one frame per start, or continuous refresh when AUTO=1.

---
 rtl/seg_shift_driver_pkg.sv | 23 ++
 rtl/seg_shift_driver_if.sv | 27 ++
 rtl/seg_clk_div.sv | 33 +++
 rtl/seg_shift_driver.sv | 138 +++++++++++++
 tb/tb_seg_shift_driver.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_shift_driver_pkg.sv
// Shared definitions for the 7-segment serial driver.
// Holds the FSM encoding and frame geometry used by the driver and its bench.
package seg_shift_driver_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SCAN_N     = 8;
    localparam int SCAN_W     = 3;
    localparam int BIT_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Width of a counter able to hold 0..d.
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/seg_shift_driver_if.sv
// Control/map-stage bundle for the segment serialiser.
// master: requester/map stage (drives start, seg_byte); slave: the driver.
interface seg_shift_driver_if;

    logic       start;
    logic [7:0] seg_byte;
    logic [2:0] scan;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output seg_byte,
        input  scan,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  seg_byte,
        output scan,
        output busy,
        output done
    );

endinterface

// File: rtl/seg_clk_div.sv
// Phase timer: tick is high on the last system clock of every DIV-clock phase.
// Ports: clk, rst_n, clr (sync clear), en (count enable), tick (phase end).
module seg_clk_div
    import seg_shift_driver_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Reloads to zero at every phase boundary so each phase is exactly DIV long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_shift_driver.sv
// Gathers eight scan bytes from the map stage into a 64-bit frame, shifts it
// out MSB-first on sclk/sdat and pulses sen. Ports: clk, rst_n, bus (start,
// seg_byte in; scan, busy, done out), sclk, sdat, sen. All outputs registered.
module seg_shift_driver
    import seg_shift_driver_pkg::*;
#(
    parameter int DIV  = 2,
    parameter bit AUTO = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_shift_driver_if.slave  bus,
    output logic               sclk,
    output logic               sdat,
    output logic               sen
);

    state_t                  st_q, st_d;
    logic [SCAN_W-1:0]       scan_q, scan_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [BIT_W-1:0]        bit_q, bit_d, bit_nx;
    logic                    sclk_q, sclk_d;
    logic                    sdat_q, sdat_d;
    logic                    sen_q, sen_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic div_en;
    logic tick;
    logic go;
    logic last_scan;
    logic last_bit;

    assign div_en    = (st_q == ST_SHIFT) || (st_q == ST_LATCH);
    assign go        = bus.start || AUTO;
    assign last_scan = (scan_q == SCAN_W'(SCAN_N - 1));
    assign last_bit  = (bit_q == '1);
    assign bit_nx    = bit_q + 1'b1;

    seg_clk_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!div_en),
        .en    (div_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            scan_q  <= '0;
            frame_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            sen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            scan_q  <= scan_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sdat_q  <= sdat_d;
            sen_q   <= sen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:   if (go) st_d = ST_GATHER;
            ST_GATHER: if (last_scan) st_d = ST_SHIFT;
            ST_SHIFT:  if (tick && sclk_q && last_bit) st_d = ST_LATCH;
            ST_LATCH:  if (tick) st_d = ST_DONE;
            ST_DONE:   st_d = AUTO ? ST_GATHER : ST_IDLE;
            default:   st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_d  = scan_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sdat_d  = sdat_q;
        sen_d   = (st_d == ST_LATCH);
        done_d  = (st_d == ST_DONE);
        busy_d  = (st_d == ST_GATHER) || (st_d == ST_SHIFT) ||
                  (st_d == ST_LATCH);
        unique case (st_q)
            ST_IDLE: begin
                if (go) scan_d = '0;
            end
            ST_GATHER: begin
                frame_d[{scan_q, 3'b000} +: 8] = bus.seg_byte;
                scan_d = scan_q + 1'b1;
                // Bit 63 is arriving this cycle, so present it directly.
                if (last_scan) begin
                    sdat_d = bus.seg_byte[7];
                    sclk_d = 1'b0;
                    bit_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        bit_d = bit_nx;
                        // Next bit goes out on the falling edge; the last
                        // bit is held through LATCH.
                        if (!last_bit) sdat_d = frame_q[~bit_nx];
                    end
                end
            end
            ST_LATCH: begin
                sclk_d = 1'b0;
            end
            ST_DONE: begin
                scan_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.scan = scan_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign sclk     = sclk_q;
    assign sdat     = sdat_q;
    assign sen      = sen_q;

endmodule

// File: tb/tb_seg_shift_driver.sv
// Self-checking bench for seg_shift_driver: three instances (DIV=1, DIV=3,
// DIV=2 with AUTO) checked against a frame/latency model of the display path.
module tb_seg_shift_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rstn;
    logic [2:0] st;
    logic [2:0] ovr;
    logic [7:0] tbl [3][8];

    int checks   = 0;
    int failures = 0;

    seg_shift_driver_if b0 ();
    seg_shift_driver_if b1 ();
    seg_shift_driver_if b2 ();

    wire [2:0] w_sclk;
    wire [2:0] w_sdat;
    wire [2:0] w_sen;
    wire [2:0] w_busy = {b2.busy, b1.busy, b0.busy};
    wire [2:0] w_done = {b2.done, b1.done, b0.done};
    wire [8:0] w_scan = {b2.scan, b1.scan, b0.scan};

    // Map stage model: combinational lookup on the scan index.
    assign b0.start    = st[0];
    assign b1.start    = st[1];
    assign b2.start    = st[2];
    assign b0.seg_byte = ovr[0] ? 8'hFF : tbl[0][b0.scan];
    assign b1.seg_byte = ovr[1] ? 8'hFF : tbl[1][b1.scan];
    assign b2.seg_byte = ovr[2] ? 8'hFF : tbl[2][b2.scan];

    seg_shift_driver #(.DIV(1), .AUTO(1'b0)) u0 (
        .clk(clk), .rst_n(rstn[0]), .bus(b0.slave),
        .sclk(w_sclk[0]), .sdat(w_sdat[0]), .sen(w_sen[0])
    );
    seg_shift_driver #(.DIV(3), .AUTO(1'b0)) u1 (
        .clk(clk), .rst_n(rstn[1]), .bus(b1.slave),
        .sclk(w_sclk[1]), .sdat(w_sdat[1]), .sen(w_sen[1])
    );
    seg_shift_driver #(.DIV(2), .AUTO(1'b1)) u2 (
        .clk(clk), .rst_n(rstn[2]), .bus(b2.slave),
        .sclk(w_sclk[2]), .sdat(w_sdat[2]), .sen(w_sen[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] outs(input int u);
        return {w_scan[3*u +: 3], w_sclk[u], w_sdat[u], w_sen[u],
                w_busy[u], w_done[u]};
    endfunction

    task automatic fill_rand(input int u);
        for (int i = 0; i < 8; i++) tbl[u][i] = 8'($urandom);
    endtask

    // Launch nf frames on instance u (called just after a negedge) and
    // compare the serial stream and event timing with the model.
    task automatic run_frames(input int u, input int d, input int nf,
                              input bit auto_m, input bit extra,
                              input bit ffo, input string tag);
        int per = 9 + 129 * d;
        int n   = nf * per + 6;
        logic [63:0] fr;
        logic [63:0] got;
        bit q[$];
        int dn[$];
        int sn[$];
        int first_rise = -1;
        int last_edge  = -1;
        int hi_min = 1 << 30, hi_max = 0;
        int lo_min = 1 << 30, lo_max = 0;
        int hold_bad = 0;
        int sen_cnt  = 0;
        bit ps = 1'b0, pd = 1'b0, pe = 1'b0;
        bit s, sd, e;
        for (int i = 0; i < 8; i++) fr[8*i +: 8] = tbl[u][i];
        if (auto_m) rstn[u] = 1'b1;
        else st[u] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            st[u]  = extra && (k == 5 || k == 50);
            ovr[u] = ffo && (k >= 9);
            s  = w_sclk[u];
            sd = w_sdat[u];
            e  = w_sen[u];
            if (k == 1) chk({tag, "_busy_rise"}, 64'(w_busy[u]), 64'd1);
            if (nf > 1 && k == per + 1)
                chk({tag, "_regather"},
                    64'({w_busy[u], w_scan[3*u +: 3]}), 64'h8);
            if (s && !ps) begin
                q.push_back(sd);
                if (first_rise < 0) first_rise = k;
                if (last_edge >= 0) begin
                    if (k - last_edge < lo_min) lo_min = k - last_edge;
                    if (k - last_edge > lo_max) lo_max = k - last_edge;
                end
                last_edge = k;
            end
            if (!s && ps) begin
                if (k - last_edge < hi_min) hi_min = k - last_edge;
                if (k - last_edge > hi_max) hi_max = k - last_edge;
                last_edge = k;
            end
            if (s && ps && sd !== pd) hold_bad++;
            if (e) begin
                sen_cnt++;
                last_edge = -1;
            end
            if (e && !pe) sn.push_back(k);
            if (w_done[u]) dn.push_back(k);
            ps = s;
            pd = sd;
            pe = e;
        end
        st[u]  = 1'b0;
        ovr[u] = 1'b0;
        chk({tag, "_first_rise"}, 64'(first_rise), 64'(9 + d));
        chk({tag, "_nbits"}, 64'(q.size()), 64'(nf * 64));
        for (int f = 0; f < nf; f++) begin
            got = '0;
            for (int i = 0; i < 64; i++)
                if (f * 64 + i < q.size()) got = {got[62:0], q[f*64+i]};
            chk({tag, "_stream"}, got, fr);
        end
        chk({tag, "_hi_min"}, 64'(hi_min), 64'(d));
        chk({tag, "_hi_max"}, 64'(hi_max), 64'(d));
        chk({tag, "_lo_min"}, 64'(lo_min), 64'(d));
        chk({tag, "_lo_max"}, 64'(lo_max), 64'(d));
        chk({tag, "_sdat_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_sen_width"}, 64'(sen_cnt), 64'(nf * d));
        chk({tag, "_ndone"}, 64'(dn.size()), 64'(nf));
        chk({tag, "_nsen"}, 64'(sn.size()), 64'(nf));
        for (int f = 0; f < nf; f++) begin
            if (f < dn.size())
                chk({tag, "_done_at"}, 64'(dn[f]), 64'((f + 1) * per));
            if (f < sn.size())
                chk({tag, "_sen_at"}, 64'(sn[f]), 64'((f + 1) * per - d));
        end
        chk({tag, "_busy_end"}, 64'(w_busy[u]), 64'(auto_m));
    endtask

    initial begin
        rstn = 3'b000;
        st   = 3'b000;
        ovr  = 3'b000;
        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 8; i++) tbl[u][i] = 8'(i);

        repeat (3) @(negedge clk);
        chk("reset_u0", 64'(outs(0)), 64'd0);
        chk("reset_u1", 64'(outs(1)), 64'd0);
        chk("reset_u2", 64'(outs(2)), 64'd0);
        rstn[1:0] = 2'b11;
        repeat (2) @(negedge clk);
        chk("idle_u0", 64'(outs(0)), 64'd0);

        // Frame order: byte k = k, DIV=1.
        run_frames(0, 1, 1, 1'b0, 1'b0, 1'b0, "order");
        repeat (3) @(negedge clk);

        // Timing at DIV=3 with random bytes.
        fill_rand(1);
        run_frames(1, 3, 1, 1'b0, 1'b0, 1'b0, "timing");
        repeat (3) @(negedge clk);

        // 0xA5 everywhere; map output forced to 0xFF during SHIFT.
        for (int i = 0; i < 8; i++) tbl[0][i] = 8'hA5;
        run_frames(0, 1, 1, 1'b0, 1'b0, 1'b1, "a5_ff");
        repeat (3) @(negedge clk);

        // Extra starts while busy are ignored.
        fill_rand(1);
        run_frames(1, 3, 1, 1'b0, 1'b1, 1'b0, "ignore");
        repeat (3) @(negedge clk);

        // Abort mid-SHIFT with asynchronous reset.
        fill_rand(0);
        st[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        chk("abort_busy_before", 64'(w_busy[0]), 64'd1);
        rstn[0] = 1'b0;
        #1;
        chk("abort_async", 64'(outs(0)), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold", 64'(outs(0)), 64'd0);
        end
        rstn[0] = 1'b1;
        @(negedge clk);
        fill_rand(0);
        run_frames(0, 1, 1, 1'b0, 1'b0, 1'b0, "after_abort");
        repeat (3) @(negedge clk);

        // AUTO: back-to-back frames from reset release.
        fill_rand(2);
        run_frames(2, 2, 2, 1'b1, 1'b0, 1'b0, "auto");
        rstn[2] = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
